// File: rtl/rotary_button_decoder_pkg.sv
// Shared types for the rotary/button front end.
// Quadrature FSM encodings and press/held bit positions.
package rotary_button_decoder_pkg;

    typedef enum logic [2:0] {
        Q_IDLE = 3'd0,
        Q_L1   = 3'd1,
        Q_L2   = 3'd2,
        Q_L3   = 3'd3,
        Q_R1   = 3'd4,
        Q_R2   = 3'd5,
        Q_R3   = 3'd6,
        Q_ERR  = 3'd7
    } quad_state_t;

    localparam int BTN_CENTER = 0;
    localparam int BTN_WEST   = 1;
    localparam int BTN_EAST   = 2;
    localparam int BTN_NORTH  = 3;
    localparam int BTN_NUM    = 4;

endpackage

// File: rtl/rotary_button_decoder_debouncer.sv
// One button: 2-FF synchroniser, stability counter, registered
// level and rising-edge pulse.
module rotary_button_decoder_debouncer #(
    parameter int DEB_CYCLES = 250_000,
    parameter int DEB_W      = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic held,
    output logic press
);

    logic [1:0]       sync;
    logic             lvl;
    logic [DEB_W-1:0] cnt;
    logic             flip;

    // lvl is the internal debounced level; held/press are its output register
    assign flip = (sync[1] != lvl) && (cnt == DEB_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            lvl   <= 1'b0;
            cnt   <= '0;
            held  <= 1'b0;
            press <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == lvl || flip) cnt <= '0;
            else                        cnt <= cnt + 1'b1;
            if (flip) lvl <= ~lvl;
            held  <= lvl;
            press <= lvl & ~held;
        end
    end

endmodule

// File: rtl/rotary_button_decoder.sv
// Board-pin front end: debounced buttons and quadrature detent decoding,
// emitting single-cycle events for the menu logic.
module rotary_button_decoder
    import rotary_button_decoder_pkg::*;
#(
    parameter int DEB_CYCLES = 250_000,
    parameter int DEB_W      = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rotary_a,
    input  logic       rotary_b,
    input  logic       rotary_center,
    input  logic       btn_west,
    input  logic       btn_east,
    input  logic       btn_north,
    output logic       rotate_left,
    output logic       rotate_right,
    output logic [3:0] press,
    output logic [3:0] held
);

    logic [BTN_NUM-1:0] raw;

    assign raw[BTN_CENTER] = rotary_center;
    assign raw[BTN_WEST]   = btn_west;
    assign raw[BTN_EAST]   = btn_east;
    assign raw[BTN_NORTH]  = btn_north;

    for (genvar i = 0; i < BTN_NUM; i++) begin : g_btn
        rotary_button_decoder_debouncer #(
            .DEB_CYCLES(DEB_CYCLES),
            .DEB_W     (DEB_W)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[i]),
            .held (held[i]),
            .press(press[i])
        );
    end

    logic [1:0]  a_sync;
    logic [1:0]  b_sync;
    logic [1:0]  q;
    logic [2:0]  warm;
    quad_state_t state;
    quad_state_t nxt;
    logic        left_nx;
    logic        right_nx;

    assign q = {a_sync[1], b_sync[1]};

    // warm[1] marks valid synchroniser output; warm[2] low flags its first cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync       <= '0;
            b_sync       <= '0;
            warm         <= '0;
            state        <= Q_IDLE;
            rotate_left  <= 1'b0;
            rotate_right <= 1'b0;
        end else begin
            a_sync       <= {a_sync[0], rotary_a};
            b_sync       <= {b_sync[0], rotary_b};
            warm         <= {warm[1:0], 1'b1};
            state        <= nxt;
            rotate_left  <= left_nx;
            rotate_right <= right_nx;
        end
    end

    always_comb begin
        nxt = state;
        if (!warm[1]) begin
            nxt = Q_IDLE;
        end else if (!warm[2] && q != 2'b00) begin
            nxt = Q_ERR;
        end else begin
            unique case (state)
                Q_IDLE:
                    case (q)
                        2'b10:   nxt = Q_L1;
                        2'b01:   nxt = Q_R1;
                        2'b11:   nxt = Q_ERR;
                        default: nxt = Q_IDLE;
                    endcase
                Q_L1:
                    case (q)
                        2'b11:   nxt = Q_L2;
                        2'b00:   nxt = Q_IDLE;
                        2'b01:   nxt = Q_ERR;
                        default: nxt = Q_L1;
                    endcase
                Q_L2:
                    case (q)
                        2'b01:   nxt = Q_L3;
                        2'b10:   nxt = Q_L1;
                        2'b00:   nxt = Q_ERR;
                        default: nxt = Q_L2;
                    endcase
                Q_L3:
                    case (q)
                        2'b00:   nxt = Q_IDLE;
                        2'b11:   nxt = Q_L2;
                        2'b10:   nxt = Q_ERR;
                        default: nxt = Q_L3;
                    endcase
                Q_R1:
                    case (q)
                        2'b11:   nxt = Q_R2;
                        2'b00:   nxt = Q_IDLE;
                        2'b10:   nxt = Q_ERR;
                        default: nxt = Q_R1;
                    endcase
                Q_R2:
                    case (q)
                        2'b10:   nxt = Q_R3;
                        2'b01:   nxt = Q_R1;
                        2'b00:   nxt = Q_ERR;
                        default: nxt = Q_R2;
                    endcase
                Q_R3:
                    case (q)
                        2'b00:   nxt = Q_IDLE;
                        2'b11:   nxt = Q_R2;
                        2'b01:   nxt = Q_ERR;
                        default: nxt = Q_R3;
                    endcase
                Q_ERR:
                    nxt = (q == 2'b00) ? Q_IDLE : Q_ERR;
            endcase
        end
    end

    always_comb begin
        left_nx  = warm[2] && (state == Q_L3) && (q == 2'b00);
        right_nx = warm[2] && (state == Q_R3) && (q == 2'b00);
    end

endmodule

// File: tb/tb_rotary_button_decoder.sv
// Bench for rotary_button_decoder: detent vector table plus hand-written
// debounce/reset sequences, checked against a cycle-stamped event queue.
module tb_rotary_button_decoder;

    localparam int DEB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rotary_a = 1'b0;
    logic       rotary_b = 1'b0;
    logic       rotary_center = 1'b0;
    logic       btn_west = 1'b0;
    logic       btn_east = 1'b0;
    logic       btn_north = 1'b0;
    logic       rotate_left;
    logic       rotate_right;
    logic [3:0] press;
    logic [3:0] held;

    rotary_button_decoder #(.DEB_CYCLES(DEB), .DEB_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .rotary_a     (rotary_a),
        .rotary_b     (rotary_b),
        .rotary_center(rotary_center),
        .btn_west     (btn_west),
        .btn_east     (btn_east),
        .btn_north    (btn_north),
        .rotate_left  (rotate_left),
        .rotate_right (rotate_right),
        .press        (press),
        .held         (held)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ev = {left, right, press[3:0]}
    typedef struct {
        int         at;
        logic [5:0] ev;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [7:0] seq;
        logic [1:0] lr;
    } vec_t;
    vec_t vecs[8];

    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;
    logic [5:0] exp_ev;
    logic [5:0] act_ev;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_ev = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    exp_ev = exp_ev | sb[i].ev;
                    sb.delete(i);
                end else if (sb[i].at < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missed_event cyc=%0d ev=%b due=%0d",
                             cyc, sb[i].ev, sb[i].at);
                    sb.delete(i);
                end
            end
            act_ev = {rotate_left, rotate_right, press};
            total++;
            if (act_ev !== exp_ev || (rotate_left && rotate_right)) begin
                bad++;
                $display("FAIL events cyc=%0d got=%b want=%b",
                         cyc, act_ev, exp_ev);
            end
        end
    end

    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input int at, input logic [5:0] ev);
        sb_t e;
        e.at = at;
        e.ev = ev;
        sb.push_back(e);
    endtask

    int n0;

    initial begin
        vecs[0] = '{8'b10_11_01_00, 2'b10};
        vecs[1] = '{8'b01_11_10_00, 2'b01};
        vecs[2] = '{8'b01_11_01_00, 2'b00};
        vecs[3] = '{8'b11_00_00_00, 2'b00};
        vecs[4] = '{8'b10_11_01_00, 2'b10};
        vecs[5] = '{8'b10_00_00_00, 2'b00};
        vecs[6] = '{8'b10_11_10_00, 2'b00};
        vecs[7] = '{8'b01_00_10_00, 2'b00};

        go(3);
        chk("reset_outs", {22'd0, rotate_left, rotate_right, press, held}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        go(4);

        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 4; k++) begin
                {rotary_a, rotary_b} = vecs[v].seq[7-2*k -: 2];
                if (k < 3) go(1);
            end
            if (vecs[v].lr != 2'b00) expect_ev(cyc + 3, {vecs[v].lr, 4'b0000});
            go(8);
        end

        // bounce on the centre push, then a clean hold and release
        for (int k = 0; k < 8; k++) begin
            rotary_center = (k % 2 == 0);
            go(5);
        end
        rotary_center = 1'b1;
        n0 = cyc;
        expect_ev(n0 + 3 + DEB, 6'b000001);
        go(2 + DEB);
        chk("held_c_pre", {28'd0, held}, 32'h0);
        go(1);
        chk("held_c_set", {28'd0, held}, 32'h1);
        go(11);
        rotary_center = 1'b0;
        go(2 + DEB);
        chk("held_c_keep", {28'd0, held}, 32'h1);
        go(1);
        chk("held_c_clr", {28'd0, held}, 32'h0);
        go(5);

        // two buttons and a detent landing in the same cycle
        n0 = cyc;
        btn_north = 1'b1;
        btn_east = 1'b1;
        expect_ev(n0 + 3 + DEB, 6'b101100);
        go(13);
        rotary_a = 1'b1;
        go(1);
        rotary_b = 1'b1;
        go(1);
        rotary_a = 1'b0;
        go(1);
        rotary_b = 1'b0;
        go(25);
        chk("held_sim", {28'd0, held}, 32'hC);
        btn_north = 1'b0;
        btn_east = 1'b0;
        go(25);
        chk("held_sim_rel", {28'd0, held}, 32'h0);

        // reset during L2 and during a west debounce; north held through it
        btn_north = 1'b1;
        expect_ev(cyc + 3 + DEB, 6'b001000);
        go(25);
        chk("held_n", {28'd0, held}, 32'h8);
        btn_west = 1'b1;
        rotary_a = 1'b1;
        go(1);
        rotary_b = 1'b1;
        go(4);
        reset = 1'b1;
        go(1);
        chk("mid_reset_outs",
            {22'd0, rotate_left, rotate_right, press, held}, 32'd0);
        reset = 1'b0;
        btn_west = 1'b0;
        rotary_a = 1'b0;
        expect_ev(cyc + 3 + DEB, 6'b001000);
        go(1);
        rotary_b = 1'b0;
        go(30);
        chk("held_n_again", {28'd0, held}, 32'h8);
        btn_north = 1'b0;
        go(25);

        // clean detent after the reset recovery
        rotary_a = 1'b1;
        go(1);
        rotary_b = 1'b1;
        go(1);
        rotary_a = 1'b0;
        go(1);
        rotary_b = 1'b0;
        expect_ev(cyc + 3, 6'b100000);
        go(8);

        chk("sb_empty", sb.size(), 32'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
